cruzamento_ctrl: RTL and testbench

CRUZAMENTO_CTRL -- requirements
Module: cruzamento_ctrl

---
 rtl/cruzamento_ctrl_pkg.sv | 35 +++
 rtl/sem_timer.sv | 24 ++
 rtl/cruzamento_ctrl.sv | 126 ++++++++++++
 tb/tb_cruzamento_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cruzamento_ctrl_pkg.sv
// Shared definitions for the two-approach intersection controller:
// phase encoding, lamp patterns and default phase durations.
package cruzamento_ctrl_pkg;

  typedef enum logic [2:0] {
    A_GRN,
    A_YEL,
    RED_AB,
    B_GRN,
    B_YEL,
    RED_BA,
    WALK
  } state_t;

  typedef enum logic {
    DIR_A,
    DIR_B
  } dir_t;

  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;

  localparam int DEF_T_GREEN_MIN = 4;
  localparam int DEF_T_GREEN_MAX = 10;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 2;
  localparam int DEF_T_WALK      = 5;

  // Durations must fit the 8-bit phase counter and be at least one cycle.
  function automatic logic dur_ok(input int t);
    return (t >= 1) && (t <= 255);
  endfunction

endpackage

// File: rtl/sem_timer.sv
// Phase timer: 8-bit saturating cycle count, cleared on every phase change,
// with a flag marking the last cycle of a fixed-duration phase.
module sem_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] dur,
  output logic [7:0] count,
  output logic       done
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == dur - 8'd1);

endmodule

// File: rtl/cruzamento_ctrl.sv
// Two-approach traffic light controller with pedestrian walk phase,
// demand-latched vehicle/pedestrian requests and min/max green timing.
module cruzamento_ctrl
  import cruzamento_ctrl_pkg::*;
#(
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqA,
  input  logic       reqB,
  input  logic       ped,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       walk
);

  if (!(dur_ok(T_GREEN_MIN) && dur_ok(T_GREEN_MAX) && dur_ok(T_YELLOW) &&
        dur_ok(T_ALLRED) && dur_ok(T_WALK) && (T_GREEN_MIN <= T_GREEN_MAX)))
  begin : g_param_err
    $error("cruzamento_ctrl: timing parameters out of range");
  end

  localparam logic [7:0] DUR_YELLOW = 8'(T_YELLOW);
  localparam logic [7:0] DUR_ALLRED = 8'(T_ALLRED);
  localparam logic [7:0] DUR_WALK   = 8'(T_WALK);
  localparam logic [8:0] GRN_MIN    = 9'(T_GREEN_MIN);
  localparam logic [8:0] GRN_MAX    = 9'(T_GREEN_MAX);

  state_t     state, state_next;
  dir_t       dir;
  logic       reqa_pend, reqb_pend, ped_pend;
  logic [7:0] count, dur;
  logic       done, phase_change;
  logic [8:0] count_next;
  logic       min_ok, max_ok;

  assign phase_change = (state_next != state);
  assign count_next   = {1'b0, count} + 9'd1;
  assign min_ok       = (count_next >= GRN_MIN);
  assign max_ok       = (count_next >= GRN_MAX);

  always_comb begin
    dur = 8'd0;
    case (state)
      A_YEL, B_YEL:   dur = DUR_YELLOW;
      RED_AB, RED_BA: dur = DUR_ALLRED;
      WALK:           dur = DUR_WALK;
      default:        dur = 8'd0;
    endcase
  end

  sem_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (phase_change),
    .dur   (dur),
    .count (count),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RED_BA;
      dir       <= DIR_A;
      reqa_pend <= 1'b0;
      reqb_pend <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == WALK && state != WALK) begin
        dir <= (state == RED_AB) ? DIR_B : DIR_A;
      end
      // Entering the serving phase clears the request even if it re-arrives that cycle.
      if (state_next == A_GRN && state != A_GRN)  reqa_pend <= 1'b0;
      else if (reqA && state != A_GRN)             reqa_pend <= 1'b1;
      if (state_next == B_GRN && state != B_GRN)  reqb_pend <= 1'b0;
      else if (reqB && state != B_GRN)             reqb_pend <= 1'b1;
      if (state_next == WALK && state != WALK)    ped_pend  <= 1'b0;
      else if (ped && state != WALK)               ped_pend  <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    A          = RED;
    B          = RED;
    walk       = 1'b0;
    case (state)
      A_GRN: begin
        A = GREEN;
        if ((min_ok && (ped_pend || (reqb_pend && !reqA))) || (max_ok && reqb_pend))
          state_next = A_YEL;
      end
      A_YEL: begin
        A = YELLOW;
        if (done) state_next = RED_AB;
      end
      RED_AB: begin
        if (done) state_next = ped_pend ? WALK : B_GRN;
      end
      B_GRN: begin
        B = GREEN;
        if ((min_ok && (ped_pend || (reqa_pend && !reqB))) || (max_ok && reqa_pend))
          state_next = B_YEL;
      end
      B_YEL: begin
        B = YELLOW;
        if (done) state_next = RED_BA;
      end
      RED_BA: begin
        if (done) state_next = ped_pend ? WALK : A_GRN;
      end
      WALK: begin
        walk = 1'b1;
        if (done) state_next = (dir == DIR_B) ? B_GRN : A_GRN;
      end
      default: state_next = RED_BA;
    endcase
  end

endmodule

// File: tb/tb_cruzamento_ctrl.sv
// Scoreboard bench for cruzamento_ctrl: directed per-cycle lamp expectations
// are queued by the stimulus and compared by an independent monitor.
module tb_cruzamento_ctrl;
  import cruzamento_ctrl_pkg::*;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       reqA = 1'b0;
  logic       reqB = 1'b0;
  logic       ped  = 1'b0;
  logic [2:0] A, B;
  logic       walk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       w;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  cruzamento_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .reqA (reqA),
    .reqB (reqB),
    .ped  (ped),
    .A    (A),
    .B    (B),
    .walk (walk)
  );

  // One cycle: drive inputs just after the edge and queue the lamps expected in that cycle.
  task automatic applyStimulus(input logic r, input logic ra, input logic rb, input logic p,
                               input logic [2:0] ea, input logic [2:0] eb, input logic ew);
    exp_t e;
    @(posedge clk);
    #1;
    rst  = r;
    reqA = ra;
    reqB = rb;
    ped  = p;
    e.a    = ea;
    e.b    = eb;
    e.w    = ew;
    e.step = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  task automatic holdRun(input int n, input logic r, input logic ra, input logic rb, input logic p,
                         input logic [2:0] ea, input logic [2:0] eb, input logic ew);
    for (int i = 0; i < n; i++) applyStimulus(r, ra, rb, p, ea, eb, ew);
  endtask

  // Pulse reset for one cycle; the next cycle after this returns is A_GRN count 0.
  task automatic restart();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (A !== e.a || B !== e.b || walk !== e.w) begin
      bad++;
      $display("[TB] FAIL lamps step %0d: got A=%b B=%b walk=%b, want A=%b B=%b walk=%b",
               e.step, A, B, walk, e.a, e.b, e.w);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    if (rst) begin
      total++;
      if (A != RED && B != RED) begin
        bad++;
        $display("[TB] FAIL conflict: got A=%b B=%b, want at least one red", A, B);
      end
    end
  end

  initial begin
    $display("[TB] start");
    // Power-up: reset, two all-red cycles, then A rests green with no demand
    holdRun(2,  1'b0, 1'b0, 1'b0, 1'b0, RED,   RED, 1'b0);
    holdRun(2,  1'b1, 1'b0, 1'b0, 1'b0, RED,   RED, 1'b0);
    holdRun(50, 1'b1, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0);

    // Short reqB pulse at A green entry: min green then handover
    restart();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, GREEN, RED, 1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, GREEN,  RED,   1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, YELLOW, RED,   1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,   1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, RED,    GREEN, 1'b0);

    // reqA held: A green maxes out at 10, then B serves and hands back
    restart();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, GREEN, RED, 1'b0);
    holdRun(9, 1'b1, 1'b1, 1'b0, 1'b0, GREEN,  RED,    1'b0);
    holdRun(3, 1'b1, 1'b1, 1'b0, 1'b0, YELLOW, RED,    1'b0);
    holdRun(2, 1'b1, 1'b1, 1'b0, 1'b0, RED,    RED,    1'b0);
    holdRun(4, 1'b1, 1'b1, 1'b0, 1'b0, RED,    GREEN,  1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, RED,    YELLOW, 1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,    1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, GREEN,  RED,    1'b0);

    // Pedestrian pulse in A green: walk after clearance, then B green unrequested
    restart();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, GREEN, RED, 1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, GREEN,  RED,   1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, YELLOW, RED,   1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,   1'b0);
    holdRun(5, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,   1'b1);
    holdRun(5, 1'b1, 1'b0, 1'b0, 1'b0, RED,    GREEN, 1'b0);

    // Reset mid B yellow drops the phase and the pending reqB
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RED, GREEN,  1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RED, GREEN,  1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, RED, YELLOW, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, RED, RED,    1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED,   RED, 1'b0);
    holdRun(8, 1'b1, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0);

    // ped and reqB together in RED_BA: walk first, then A, then B
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, RED, RED, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0);
    holdRun(5, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,   1'b1);
    holdRun(4, 1'b1, 1'b0, 1'b0, 1'b0, GREEN,  RED,   1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, YELLOW, RED,   1'b0);
    holdRun(2, 1'b1, 1'b0, 1'b0, 1'b0, RED,    RED,   1'b0);
    holdRun(3, 1'b1, 1'b0, 1'b0, 1'b0, RED,    GREEN, 1'b0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
